// File: rtl/rv_pkg.sv
// Shared RISC-V LSU definitions: opcode/funct3 codes and the LSU state encoding.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LOAD_LB  = 3'd0;
  localparam logic [2:0] F3_LOAD_LH  = 3'd1;
  localparam logic [2:0] F3_LOAD_LW  = 3'd2;
  localparam logic [2:0] F3_LOAD_LD  = 3'd3;
  localparam logic [2:0] F3_LOAD_LBU = 3'd4;
  localparam logic [2:0] F3_LOAD_LHU = 3'd5;
  localparam logic [2:0] F3_LOAD_LWU = 3'd6;

  localparam logic [2:0] F3_STORE_SB = 3'd0;
  localparam logic [2:0] F3_STORE_SH = 3'd1;
  localparam logic [2:0] F3_STORE_SW = 3'd2;
  localparam logic [2:0] F3_STORE_SD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic: legality/alignment check, store strobes and data
// placement, load lane extraction with sign/zero extension.
module rv_lsu_align
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                      write,
  input  logic [2:0]                func3,
  input  logic [$clog2(XLEN/8)-1:0] lane,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rdata,
  output logic                      legal_c,
  output logic [XLEN/8-1:0]         wstrb_c,
  output logic [XLEN-1:0]           wdata_c,
  output logic [XLEN-1:0]           rdata_c
);

  localparam int unsigned STRB_W  = XLEN / 8;
  localparam int unsigned LANE_W  = $clog2(STRB_W);
  localparam logic        IS_RV64 = (XLEN == 64);

  logic              f3_ok;
  logic              sbit;
  logic [LANE_W-1:0] amask;
  logic [7:0]        size_mask;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   keep;
  logic [LANE_W+2:0] bit_sh;

  assign bit_sh = {lane, 3'b000};

  // Width codes are shared by loads and stores in func3[1:0]; func3[2] marks unsigned loads.
  always_comb begin
    f3_ok = 1'b0;
    if (write) begin
      case (func3)
        F3_STORE_SB, F3_STORE_SH, F3_STORE_SW: f3_ok = 1'b1;
        F3_STORE_SD:                           f3_ok = IS_RV64;
        default:                               f3_ok = 1'b0;
      endcase
    end else begin
      case (func3)
        F3_LOAD_LB, F3_LOAD_LH, F3_LOAD_LW,
        F3_LOAD_LBU, F3_LOAD_LHU:              f3_ok = 1'b1;
        F3_LOAD_LD, F3_LOAD_LWU:               f3_ok = IS_RV64;
        default:                               f3_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    amask     = '0;
    size_mask = 8'h01;
    keep      = '1;
    shifted   = rdata >> bit_sh;
    sbit      = shifted[XLEN-1];
    case (func3[1:0])
      2'd0: begin
        amask = '0;            size_mask = 8'h01;
        keep  = XLEN'(8'hFF);  sbit      = shifted[7];
      end
      2'd1: begin
        amask = LANE_W'(1);       size_mask = 8'h03;
        keep  = XLEN'(16'hFFFF);  sbit      = shifted[15];
      end
      2'd2: begin
        amask = LANE_W'(3);            size_mask = 8'h0F;
        keep  = XLEN'(32'hFFFF_FFFF);  sbit      = shifted[31];
      end
      default: begin
        amask = LANE_W'(7);  size_mask = 8'hFF;
        keep  = '1;          sbit      = shifted[XLEN-1];
      end
    endcase
  end

  assign legal_c = f3_ok && ((lane & amask) == '0);
  assign wstrb_c = STRB_W'(size_mask) << lane;
  assign wdata_c = wdata << bit_sh;
  assign rdata_c = (shifted & keep) | ((!func3[2] && sbit) ? ~keep : '0);

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: accepts one core request, runs a single memory access and
// returns load write-back or a misalignment/illegal-access error.
module rv_lsu
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_func3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                pend_valid,
  output logic [4:0]          pend_rd,
  output logic                err_valid,
  output logic [ADDR_W-1:0]   err_addr
);

  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned LANE_W = $clog2(STRB_W);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        func3_q, func3_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [4:0]        rd_q, rd_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              pend_valid_q, pend_valid_d;
  logic [4:0]        pend_rd_q, pend_rd_d;
  logic              err_valid_q, err_valid_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic              idle_c, accept_c, load_rd_c;
  logic              a_write_c, legal_c;
  logic [2:0]        a_func3_c;
  logic [LANE_W-1:0] a_lane_c;
  logic [STRB_W-1:0] wstrb_c;
  logic [XLEN-1:0]   wdata_c, rdata_c;

  // Ready is held low while reset is asserted so nothing is accepted then.
  assign idle_c    = (state_q == ST_IDLE);
  assign req_ready = idle_c && rst_n;
  assign accept_c  = req_valid && req_ready;
  assign load_rd_c = !req_write && (req_rd != 5'd0);

  // Align unit sees the live request in IDLE and the latched one afterwards.
  assign a_write_c = idle_c ? req_write : write_q;
  assign a_func3_c = idle_c ? req_func3 : func3_q;
  assign a_lane_c  = idle_c ? req_addr[LANE_W-1:0] : lane_q;

  rv_lsu_align #(.XLEN(XLEN)) u_align (
    .write   (a_write_c),
    .func3   (a_func3_c),
    .lane    (a_lane_c),
    .wdata   (req_wdata),
    .rdata   (mem_rdata),
    .legal_c (legal_c),
    .wstrb_c (wstrb_c),
    .wdata_c (wdata_c),
    .rdata_c (rdata_c)
  );

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    func3_d      = func3_q;
    lane_d       = lane_q;
    rd_d         = rd_q;
    mem_valid_d  = mem_valid_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = '0;
    wb_data_d    = '0;
    err_valid_d  = 1'b0;
    err_addr_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          write_d = req_write;
          func3_d = req_func3;
          lane_d  = req_addr[LANE_W-1:0];
          rd_d    = req_rd;
          if (legal_c) begin
            state_d      = ST_MEM;
            mem_valid_d  = 1'b1;
            mem_write_d  = req_write;
            mem_addr_d   = req_addr & ~ADDR_W'(STRB_W - 1);
            mem_wstrb_d  = req_write ? wstrb_c : '0;
            mem_wdata_d  = req_write ? wdata_c : '0;
            pend_valid_d = load_rd_c;
            pend_rd_d    = load_rd_c ? req_rd : '0;
          end else begin
            state_d     = ST_RESP;
            err_valid_d = 1'b1;
            err_addr_d  = req_addr;
          end
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d     = ST_RESP;
          mem_valid_d = 1'b0;
          mem_write_d = 1'b0;
          mem_addr_d  = '0;
          mem_wstrb_d = '0;
          mem_wdata_d = '0;
          if (!write_q && (rd_q != 5'd0)) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = rdata_c;
          end
        end
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        pend_valid_d = 1'b0;
        pend_rd_d    = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      func3_q      <= '0;
      lane_q       <= '0;
      rd_q         <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= '0;
      mem_wdata_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      err_valid_q  <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      func3_q      <= func3_d;
      lane_q       <= lane_d;
      rd_q         <= rd_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      err_valid_q  <= err_valid_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign mem_valid  = mem_valid_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign pend_valid = pend_valid_q;
  assign pend_rd    = pend_rd_q;
  assign err_valid  = err_valid_q;
  assign err_addr   = err_addr_q;

endmodule

// File: doc/rv_lsu.md
RV_LSU -- requirements
Module: rv_lsu

Interface
REQ-001 Parameter XLEN, 32, data/register width; legal values 32 and 64.
REQ-002 Parameter ADDR_W, 32, byte-address width of the memory port.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 req_valid  input  1  core presents a load/store.
REQ-006 req_ready  output  1  LSU accepts the request; transfer occurs when req_valid and req_ready are both 1 on a clock edge.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_func3  input  3  RISC-V funct3 width/sign code.
REQ-009 req_addr  input  ADDR_W  effective byte address (rs1 + offset, computed by the core).
REQ-010 req_wdata  input  XLEN  store data (rs2).
REQ-011 req_rd  input  5  load destination register.
REQ-012 mem_valid  output  1  memory access pending.
REQ-013 mem_ready  input  1  memory completes the access; for loads, mem_rdata is valid in the same cycle.
REQ-014 mem_write, mem_addr[ADDR_W], mem_wstrb[XLEN/8], mem_wdata[XLEN]  outputs  write flag, XLEN/8-aligned address, byte strobes, lane-positioned data.
REQ-015 mem_rdata  input  XLEN  read data.
REQ-016 wb_valid, wb_rd[5], wb_data[XLEN]  outputs  one-cycle load write-back.
REQ-017 pend_valid, pend_rd[5]  outputs  load in flight and its rd, for core hazard stalls.
REQ-018 err_valid, err_addr[ADDR_W]  outputs  one-cycle misaligned/illegal access report.

Function
REQ-019 FSM states: IDLE, MEM, RESP; req_ready = 1 only in IDLE.
REQ-020 Accept in IDLE: latch all request fields and compute lane = addr[log2(XLEN/8)-1:0]. A legal request goes to MEM; an illegal one goes to RESP with error set and never asserts mem_valid.
REQ-021 Legal load func3: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; 3 LD and 6 LWU are legal only when XLEN=64. Legal store func3: 0 SB, 1 SH, 2 SW; 3 SD is legal only when XLEN=64. Every other code is illegal.
REQ-022 Misaligned is illegal: a halfword needs addr[0]=0, a word needs addr[1:0]=0, a doubleword needs addr[2:0]=0.
REQ-023 MEM: mem_valid = 1; mem_addr, mem_write, mem_wstrb and mem_wdata are held stable until the cycle mem_ready = 1, then the FSM goes to RESP. Wait states are unbounded.
REQ-024 mem_addr = latched addr with the low log2(XLEN/8) bits zeroed.
REQ-025 Store strobes = size mask (0x1, 0x3, 0xF or 0xFF) shifted left by lane; mem_wdata = req_wdata shifted left by 8*lane. Load mem_wstrb = 0.
REQ-026 A load captures mem_rdata in the mem_ready cycle and shifts it right by 8*lane. It is sign-extended for LB, LH and LW(XLEN=64), and zero-extended for LBU, LHU and LWU.
REQ-027 RESP lasts exactly one cycle, then the FSM returns to IDLE. In RESP: wb_valid = 1 for a load with rd != 0; err_valid = 1 with err_addr = latched addr for an illegal request; no wb_valid is produced for stores or errors.
REQ-028 pend_valid = 1 from the acceptance edge of a load with rd != 0 through the RESP cycle inclusive; pend_rd = the latched rd.
REQ-029 When no load is pending, pend_rd, wb_rd and wb_data are 0.
REQ-030 Back-to-back throughput: at most one request per 3 cycles, plus memory wait states.

Reset
REQ-031 While reset = 0, asynchronously: state = IDLE; mem_valid, wb_valid, err_valid and pend_valid = 0; all data, address and strobe outputs = 0; req_ready = 0.
REQ-032 Reset asserted mid-MEM aborts the access: mem_valid drops without waiting for mem_ready, and no wb_valid or err_valid follows.
REQ-033 The first request can be accepted on the first rising edge after reset returns to 1.

Structure
REQ-034 Opcode and funct3 constants (the F3_LOAD_* and F3_STORE_* codes) and the FSM state encoding SHALL live in shared package rv_pkg.
REQ-035 Lane alignment, strobe generation and load extension SHALL be one combinational sub-module, rv_lsu_align.
REQ-036 rv_lsu holds only the FSM and the latches.

Verification
REQ-037 XLEN=32: SW with addr 0x100 and wdata 0xDEADBEEF, mem_ready after 2 wait cycles -> mem_addr 0x100, mem_wstrb 0xF, mem_wdata 0xDEADBEEF, no wb_valid.
REQ-038 XLEN=32: LB with addr 0x203, mem_rdata 0x80FF_0000, rd 5 -> wb_valid, wb_rd 5, wb_data 0xFFFFFF80. The same access as LBU -> 0x00000080.
REQ-039 XLEN=32: SH with addr 0x102 and wdata 0x1234 -> mem_wstrb 0xC, mem_wdata 0x12340000.
REQ-040 LW with addr 0x101 -> err_valid with err_addr 0x101 one cycle after acceptance, mem_valid never asserts. LD at XLEN=32 -> err_valid.
REQ-041 XLEN=64: LWU with addr 0x1004 and mem_rdata 0x8000_0001_0000_0000 -> wb_data 0x0000_0000_8000_0001. SD with addr 0x1008 -> mem_wstrb 0xFF.
REQ-042 Reset driven to 0 in MEM with mem_ready held at 0 -> mem_valid and pend_valid fall to 0 immediately, and no wb_valid follows reset release.
